// File: rtl/ex_stage_pkg.sv
// Shared bus widths, ALU/operand-select encodings and mul/div FSM states for the EX stage.
package ex_stage_pkg;

  localparam int unsigned WordW    = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned AluSrcW  = 2;
  localparam int unsigned AluCtrlW = 5;

  // Operand selects; codes 2 and 3 select zero on either side.
  localparam logic [AluSrcW-1:0] Src1Rs    = 2'd0;
  localparam logic [AluSrcW-1:0] Src1Shamt = 2'd1;
  localparam logic [AluSrcW-1:0] Src2Rt    = 2'd0;
  localparam logic [AluSrcW-1:0] Src2Imm   = 2'd1;

  localparam logic [AluCtrlW-1:0] AluAdd   = 5'd0;
  localparam logic [AluCtrlW-1:0] AluAddu  = 5'd1;
  localparam logic [AluCtrlW-1:0] AluSub   = 5'd2;
  localparam logic [AluCtrlW-1:0] AluSubu  = 5'd3;
  localparam logic [AluCtrlW-1:0] AluAnd   = 5'd4;
  localparam logic [AluCtrlW-1:0] AluOr    = 5'd5;
  localparam logic [AluCtrlW-1:0] AluXor   = 5'd6;
  localparam logic [AluCtrlW-1:0] AluNor   = 5'd7;
  localparam logic [AluCtrlW-1:0] AluSlt   = 5'd8;
  localparam logic [AluCtrlW-1:0] AluSltu  = 5'd9;
  localparam logic [AluCtrlW-1:0] AluSll   = 5'd10;
  localparam logic [AluCtrlW-1:0] AluSrl   = 5'd11;
  localparam logic [AluCtrlW-1:0] AluSra   = 5'd12;
  localparam logic [AluCtrlW-1:0] AluLui   = 5'd13;
  localparam logic [AluCtrlW-1:0] AluMult  = 5'd14;
  localparam logic [AluCtrlW-1:0] AluMultu = 5'd15;
  localparam logic [AluCtrlW-1:0] AluDiv   = 5'd16;
  localparam logic [AluCtrlW-1:0] AluDivu  = 5'd17;
  localparam logic [AluCtrlW-1:0] AluMfhi  = 5'd18;
  localparam logic [AluCtrlW-1:0] AluMflo  = 5'd19;
  localparam logic [AluCtrlW-1:0] AluMthi  = 5'd20;
  localparam logic [AluCtrlW-1:0] AluMtlo  = 5'd21;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } md_state_e;

  // Absolute value when the operand is treated as signed; raw value otherwise.
  function automatic logic [WordW-1:0] magnitude(input logic [WordW-1:0] v, input logic sgn);
    return (sgn && v[WordW-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply / restoring divide with HI/LO registers.
// Only built when EX_MULDIV_EN is defined.
`ifdef EX_MULDIV_EN
module muldiv_unit
  import ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [AluCtrlW-1:0] op_i,
  input  logic [WordW-1:0]    rs_i,
  input  logic [WordW-1:0]    rt_i,
  output logic                busy_o,
  output logic [WordW-1:0]    hi_o,
  output logic [WordW-1:0]    lo_o
);

  md_state_e    state_q;
  logic [4:0]   count_q;
  logic [63:0]  acc_q, acc_d;
  logic [31:0]  opnd_q, dvd_q;
  logic         div_q, neg_res_q, neg_rem_q, dz_q;
  logic [31:0]  hi_q, lo_q;

  logic         start, op_signed, op_div;
  logic [32:0]  mul_sum, div_shift, div_diff;
  logic [63:0]  prod;
  logic [31:0]  quo, rem, a_mag, b_mag;

  assign op_signed = (op_i == AluMult) || (op_i == AluDiv);
  assign op_div    = (op_i == AluDiv)  || (op_i == AluDivu);
  assign start     = (op_i == AluMult) || (op_i == AluMultu) || op_div;
  assign a_mag     = magnitude(rs_i, op_signed);
  assign b_mag     = magnitude(rt_i, op_signed);

  assign busy_o = ((state_q == StIdle) && start) || (state_q == StRun);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  // acc holds {partial product} for mul, {remainder, quotient} for div.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = acc_q[63:31];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_q) begin
      acc_d = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                           : {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[31:1]};
    end
    prod = neg_res_q ? (64'd0 - acc_d) : acc_d;
    quo  = neg_res_q ? (32'd0 - acc_d[31:0]) : acc_d[31:0];
    rem  = neg_rem_q ? (32'd0 - acc_d[63:32]) : acc_d[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= 5'd0;
      acc_q     <= '0;
      opnd_q    <= '0;
      dvd_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (!busy_o && (op_i == AluMthi)) hi_q <= rs_i;
      if (!busy_o && (op_i == AluMtlo)) lo_q <= rs_i;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StRun;
            count_q   <= 5'd0;
            div_q     <= op_div;
            acc_q     <= {32'd0, op_div ? a_mag : b_mag};
            opnd_q    <= op_div ? b_mag : a_mag;
            dvd_q     <= rs_i;
            dz_q      <= (rt_i == 32'd0);
            neg_res_q <= op_signed && (rs_i[31] ^ rt_i[31]);
            neg_rem_q <= op_signed && rs_i[31];
          end
        end
        StRun: begin
          acc_q   <= acc_d;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q <= StDone;
            if (!div_q) begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end else if (dz_q) begin
              hi_q <= dvd_q;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= rem;
              lo_q <= quo;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
`endif

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, operand muxes, single-cycle ALU and optional
// iterative mul/div unit (enabled by EX_MULDIV_EN).
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [WordW-1:0]    ex_reg1,
  input  logic [WordW-1:0]    ex_reg2,
  input  logic [WordW-1:0]    ex_instant,
  input  logic [WordW-1:0]    ex_shamt,
  input  logic [AluSrcW-1:0]  ex_alusrc1,
  input  logic [AluSrcW-1:0]  ex_alusrc2,
  input  logic [AluCtrlW-1:0] ex_aluctrl,
  input  logic [RegAddrW-1:0] ex_rs_num,
  input  logic [RegAddrW-1:0] ex_rt_num,
  input  logic                mem_regwrite,
  input  logic [RegAddrW-1:0] mem_regaddr,
  input  logic [WordW-1:0]    mem_result,
  input  logic                wb_regwrite,
  input  logic [RegAddrW-1:0] wb_regaddr,
  input  logic [WordW-1:0]    wb_result,
  output logic [WordW-1:0]    alu_result,
  output logic [WordW-1:0]    store_data,
  output logic                ovf,
  output logic                busy
);

  logic [WordW-1:0] fwd_rs, fwd_rt, src1, src2, add_res, sub_res;
  logic             mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;

  assign mem_hit_rs = mem_regwrite && (mem_regaddr != '0) && (mem_regaddr == ex_rs_num);
  assign mem_hit_rt = mem_regwrite && (mem_regaddr != '0) && (mem_regaddr == ex_rt_num);
  assign wb_hit_rs  = wb_regwrite && (wb_regaddr != '0) && (wb_regaddr == ex_rs_num);
  assign wb_hit_rt  = wb_regwrite && (wb_regaddr != '0) && (wb_regaddr == ex_rt_num);

  // MEM is the younger producer, so it takes priority over WB.
  assign fwd_rs = mem_hit_rs ? mem_result : (wb_hit_rs ? wb_result : ex_reg1);
  assign fwd_rt = mem_hit_rt ? mem_result : (wb_hit_rt ? wb_result : ex_reg2);
  assign store_data = fwd_rt;

  always_comb begin
    case (ex_alusrc1)
      Src1Rs:    src1 = fwd_rs;
      Src1Shamt: src1 = ex_shamt;
      default:   src1 = '0;
    endcase
    case (ex_alusrc2)
      Src2Rt:  src2 = fwd_rt;
      Src2Imm: src2 = ex_instant;
      default: src2 = '0;
    endcase
  end

  assign add_res = src1 + src2;
  assign sub_res = src1 - src2;

`ifdef EX_MULDIV_EN
  logic [WordW-1:0] hi, lo;

  muldiv_unit u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .op_i   (ex_aluctrl),
    .rs_i   (fwd_rs),
    .rt_i   (fwd_rt),
    .busy_o (busy),
    .hi_o   (hi),
    .lo_o   (lo)
  );
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    alu_result = '0;
    ovf        = 1'b0;
    case (ex_aluctrl)
      AluAdd: begin
        alu_result = add_res;
        ovf        = (src1[31] == src2[31]) && (add_res[31] != src1[31]);
      end
      AluAddu: alu_result = add_res;
      AluSub: begin
        alu_result = sub_res;
        ovf        = (src1[31] != src2[31]) && (sub_res[31] != src1[31]);
      end
      AluSubu: alu_result = sub_res;
      AluAnd:  alu_result = src1 & src2;
      AluOr:   alu_result = src1 | src2;
      AluXor:  alu_result = src1 ^ src2;
      AluNor:  alu_result = ~(src1 | src2);
      AluSlt:  alu_result = {31'd0, $signed(src1) < $signed(src2)};
      AluSltu: alu_result = {31'd0, src1 < src2};
      AluSll:  alu_result = src2 << src1[4:0];
      AluSrl:  alu_result = src2 >> src1[4:0];
      AluSra:  alu_result = $unsigned($signed(src2) >>> src1[4:0]);
      AluLui:  alu_result = {src2[15:0], 16'h0000};
`ifdef EX_MULDIV_EN
      AluMfhi: alu_result = hi;
      AluMflo: alu_result = lo;
      AluMult, AluMultu, AluDiv, AluDivu, AluMthi, AluMtlo: alu_result = '0;
`else
      AluMult, AluMultu, AluDiv, AluDivu, AluMfhi, AluMflo, AluMthi, AluMtlo:
        alu_result = '0;
`endif
      default: alu_result = '0;
    endcase
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; mul/div checks only when EX_MULDIV_EN is defined.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_reg1, ex_reg2, ex_instant, ex_shamt;
  logic [1:0]  ex_alusrc1, ex_alusrc2;
  logic [4:0]  ex_aluctrl, ex_rs_num, ex_rt_num;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_regaddr, wb_regaddr;
  logic [31:0] mem_result, wb_result;
  logic [31:0] alu_result, store_data;
  logic        ovf, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ex_reg1      (ex_reg1),
    .ex_reg2      (ex_reg2),
    .ex_instant   (ex_instant),
    .ex_shamt     (ex_shamt),
    .ex_alusrc1   (ex_alusrc1),
    .ex_alusrc2   (ex_alusrc2),
    .ex_aluctrl   (ex_aluctrl),
    .ex_rs_num    (ex_rs_num),
    .ex_rt_num    (ex_rt_num),
    .mem_regwrite (mem_regwrite),
    .mem_regaddr  (mem_regaddr),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_regaddr   (wb_regaddr),
    .wb_result    (wb_result),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .ovf          (ovf),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_aluctrl = op;
    ex_reg1    = a;
    ex_reg2    = b;
    #1;
  endtask

`ifdef EX_MULDIV_EN
  // Launches a mul/div and counts busy cycles; returns in the DONE cycle.
  task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy);
    next_cycle();
    ex_aluctrl = op;
    ex_reg1    = a;
    ex_reg2    = b;
    #1;
    nbusy = 0;
    while (busy && nbusy < 60) begin
      nbusy++;
      next_cycle();
    end
  endtask
`endif

  initial begin
    int nb;
    rst = 1'b1;
    ex_reg1 = '0; ex_reg2 = '0; ex_instant = '0; ex_shamt = '0;
    ex_alusrc1 = 2'd0; ex_alusrc2 = 2'd0; ex_aluctrl = 5'd0;
    ex_rs_num = '0; ex_rt_num = '0;
    mem_regwrite = 1'b0; mem_regaddr = '0; mem_result = '0;
    wb_regwrite = 1'b0; wb_regaddr = '0; wb_result = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    chk("reset_alu_result", alu_result, 32'h0);
    chk("reset_store_data", store_data, 32'h0);
    chk("reset_ovf", {31'd0, ovf}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);

    alu(5'd0, 32'h7FFF_FFFF, 32'h1);
    chk("add_result", alu_result, 32'h8000_0000);
    chk("add_ovf", {31'd0, ovf}, 32'h1);
    alu(5'd1, 32'h7FFF_FFFF, 32'h1);
    chk("addu_result", alu_result, 32'h8000_0000);
    chk("addu_ovf", {31'd0, ovf}, 32'h0);
    alu(5'd2, 32'h8000_0000, 32'h1);
    chk("sub_result", alu_result, 32'h7FFF_FFFF);
    chk("sub_ovf", {31'd0, ovf}, 32'h1);
    alu(5'd8, 32'hFFFF_FFFF, 32'h1);
    chk("slt", alu_result, 32'h1);
    alu(5'd9, 32'hFFFF_FFFF, 32'h1);
    chk("sltu", alu_result, 32'h0);
    alu(5'd7, 32'h0F0F_0000, 32'h0000_00F0);
    chk("nor", alu_result, 32'hF0F0_FF0F);
    alu(5'd25, 32'h1234_5678, 32'h1);
    chk("undefined_code", alu_result, 32'h0);

    ex_alusrc1 = 2'd2;
    alu(5'd1, 32'd5, 32'd9);
    chk("src1_zero", alu_result, 32'd9);
    ex_alusrc1 = 2'd1;
    ex_shamt   = 32'd4;
    alu(5'd12, 32'h0, 32'h8000_0000);
    chk("sra", alu_result, 32'hF800_0000);
    alu(5'd11, 32'h0, 32'h8000_0000);
    chk("srl", alu_result, 32'h0800_0000);
    ex_alusrc1 = 2'd0;
    ex_alusrc2 = 2'd1;
    ex_instant = 32'h0000_1234;
    alu(5'd13, 32'h0, 32'h0);
    chk("lui", alu_result, 32'h1234_0000);
    ex_alusrc2 = 2'd0;

    ex_rs_num = 5'd5; ex_rt_num = 5'd5;
    mem_regwrite = 1'b1; mem_regaddr = 5'd5; mem_result = 32'd11;
    wb_regwrite = 1'b1; wb_regaddr = 5'd5; wb_result = 32'd22;
    alu(5'd1, 32'd100, 32'd0);
    chk("fwd_mem_priority", alu_result, 32'd22);
    chk("fwd_store_mem", store_data, 32'd11);
    ex_alusrc2 = 2'd2;
    #1;
    chk("fwd_rs_mem", alu_result, 32'd11);
    mem_regwrite = 1'b0;
    #1;
    chk("fwd_rs_wb", alu_result, 32'd22);
    ex_rs_num = 5'd0; ex_rt_num = 5'd0;
    mem_regwrite = 1'b1; mem_regaddr = 5'd0; wb_regaddr = 5'd0;
    #1;
    chk("fwd_reg0_none", alu_result, 32'd100);
    mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    ex_alusrc2 = 2'd0;

`ifdef EX_MULDIV_EN
    alu(5'd18, 32'h0, 32'h0);
    chk("reset_hi", alu_result, 32'h0);
    run_md(5'd14, 32'hFFFF_FFFD, 32'd7, nb);
    chk("mult_busy_cycles", nb, 33);
    chk("mult_result_zero", alu_result, 32'h0);
    alu(5'd18, 32'h0, 32'h0);
    chk("mult_hi_done", alu_result, 32'hFFFF_FFFF);
    next_cycle();
    alu(5'd19, 32'h0, 32'h0);
    chk("mult_lo_next", alu_result, 32'hFFFF_FFEB);

    run_md(5'd16, 32'hFFFF_FFF9, 32'd2, nb);
    chk("div_busy_cycles", nb, 33);
    alu(5'd19, 32'h0, 32'h0);
    chk("div_lo", alu_result, 32'hFFFF_FFFD);
    alu(5'd18, 32'h0, 32'h0);
    chk("div_hi", alu_result, 32'hFFFF_FFFF);

    run_md(5'd17, 32'd10, 32'd0, nb);
    alu(5'd19, 32'h0, 32'h0);
    chk("divz_lo", alu_result, 32'hFFFF_FFFF);
    alu(5'd18, 32'h0, 32'h0);
    chk("divz_hi", alu_result, 32'd10);

    next_cycle();
    alu(5'd20, 32'h0000_ABCD, 32'h0);
    next_cycle();
    alu(5'd18, 32'h0, 32'h0);
    chk("mthi", alu_result, 32'h0000_ABCD);

    alu(5'd15, 32'd6, 32'd7);
    chk("start_busy_comb", {31'd0, busy}, 32'h1);
    for (int i = 0; i < 11; i++) next_cycle();
    rst = 1'b1;
    ex_aluctrl = 5'd0;
    next_cycle();
    rst = 1'b0;
    #1;
    chk("rst_run_busy", {31'd0, busy}, 32'h0);
    alu(5'd18, 32'h0, 32'h0);
    chk("rst_run_hi", alu_result, 32'h0);
    alu(5'd19, 32'h0, 32'h0);
    chk("rst_run_lo", alu_result, 32'h0);
    run_md(5'd15, 32'd6, 32'd7, nb);
    chk("restart_busy_cycles", nb, 33);
    alu(5'd19, 32'h0, 32'h0);
    chk("restart_lo", alu_result, 32'd42);
    alu(5'd18, 32'h0, 32'h0);
    chk("restart_hi", alu_result, 32'h0);
`else
    alu(5'd14, 32'hFFFF_FFFD, 32'd7);
    chk("mult_disabled_busy", {31'd0, busy}, 32'h0);
    chk("mult_disabled_result", alu_result, 32'h0);
    next_cycle();
    alu(5'd20, 32'h0000_ABCD, 32'h0);
    next_cycle();
    alu(5'd18, 32'h0, 32'h0);
    chk("mfhi_disabled", alu_result, 32'h0);
    alu(5'd19, 32'h0, 32'h0);
    chk("mflo_disabled", alu_result, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
